// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar adjust path: field indices,
// controller state encoding and the field-enable one-hot helpers.
package clock_pkg;

  localparam int unsigned ADJ_W = 7;

  localparam int unsigned FLD_SEC   = 0;
  localparam int unsigned FLD_MIN   = 1;
  localparam int unsigned FLD_HOUR  = 2;
  localparam int unsigned FLD_DAY   = 3;
  localparam int unsigned FLD_MONTH = 4;
  localparam int unsigned FLD_YEAR  = 5;
  localparam int unsigned FLD_CENT  = 6;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SEC   = 3'd1,
    ST_MIN   = 3'd2,
    ST_HOUR  = 3'd3,
    ST_DAY   = 3'd4,
    ST_MONTH = 3'd5,
    ST_YEAR  = 3'd6,
    ST_CENT  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_t;

  function automatic state_t next_field(input state_t s);
    state_t n;
    case (s)
      ST_RUN:   n = ST_SEC;
      ST_SEC:   n = ST_MIN;
      ST_MIN:   n = ST_HOUR;
      ST_HOUR:  n = ST_DAY;
      ST_DAY:   n = ST_MONTH;
      ST_MONTH: n = ST_YEAR;
      ST_YEAR:  n = ST_CENT;
      default:  n = ST_RUN;
    endcase
    return n;
  endfunction

  function automatic logic [ADJ_W-1:0] field_onehot(input state_t s);
    logic [ADJ_W-1:0] oh;
    oh = '0;
    case (s)
      ST_SEC:   oh[FLD_SEC]   = 1'b1;
      ST_MIN:   oh[FLD_MIN]   = 1'b1;
      ST_HOUR:  oh[FLD_HOUR]  = 1'b1;
      ST_DAY:   oh[FLD_DAY]   = 1'b1;
      ST_MONTH: oh[FLD_MONTH] = 1'b1;
      ST_YEAR:  oh[FLD_YEAR]  = 1'b1;
      ST_CENT:  oh[FLD_CENT]  = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// single-cycle rise strobe aligned with the first debounced-high cycle.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Count consecutive disagreements; any agreement leaves cnt_d at zero.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/adjust_ctrl.sv
// Front-panel time-setting controller: mode button walks the field select,
// up/down produce single-cycle step pulses with auto-repeat, idle timeout to RUN.
module adjust_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_RATE     = 100,
  parameter int unsigned TIMEOUT_S       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             t_1s,
  output logic [ADJ_W-1:0] adj_en,
  output logic             adj_up,
  output logic             adj_down,
  output logic [2:0]       field_sel,
  output logic             blink
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_S + 1);

  logic mode_lvl, mode_rise;
  logic up_lvl, up_rise;
  logic down_lvl, down_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .level(mode_lvl), .rise(mode_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .level(up_lvl), .rise(up_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .level(down_lvl), .rise(down_rise)
  );

  state_t              state_q, state_d;
  step_t               act_q, act_d;
  logic                rep_run_q, rep_run_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                blink_q, blink_d;
  logic                adj_up_q, adj_up_d;
  logic                adj_down_q, adj_down_d;
  logic [ADJ_W-1:0]    adj_en_q, adj_en_d;
  logic [2:0]          field_sel_q, field_sel_d;
  logic                any_rise;
  logic                held_ok;
  logic [REP_W-1:0]    rep_last;

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    rep_run_d  = rep_run_q;
    rep_cnt_d  = rep_cnt_q;
    idle_d     = idle_q;
    blink_d    = blink_q;
    adj_up_d   = 1'b0;
    adj_down_d = 1'b0;
    any_rise   = mode_rise | up_rise | down_rise;
    held_ok    = ((act_q == STEP_UP) && up_lvl) || ((act_q == STEP_DOWN) && down_lvl);
    rep_last   = rep_run_q ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);

    // State changes (mode, timeout) win over any step activity and wipe the
    // step/repeat tracking, so a held button needs a fresh press afterwards.
    if (state_q == ST_RUN || mode_rise ||
        (t_1s && !any_rise && idle_q == IDLE_W'(TIMEOUT_S - 1))) begin
      if (mode_rise) begin
        state_d = next_field(state_q);
      end else if (state_q != ST_RUN) begin
        state_d = ST_RUN;
      end
      act_d     = STEP_NONE;
      rep_run_d = 1'b0;
      rep_cnt_d = '0;
      idle_d    = '0;
      blink_d   = 1'b0;
    end else begin
      if (any_rise) begin
        idle_d = '0;
      end else if (t_1s) begin
        idle_d = idle_q + 1'b1;
      end
      if (t_1s) begin
        blink_d = ~blink_q;
      end

      if (up_lvl && down_lvl) begin
        act_d     = STEP_NONE;
        rep_run_d = 1'b0;
        rep_cnt_d = '0;
      end else if (up_rise && !down_lvl) begin
        adj_up_d  = 1'b1;
        act_d     = STEP_UP;
        rep_run_d = 1'b0;
        rep_cnt_d = '0;
      end else if (down_rise && !up_lvl) begin
        adj_down_d = 1'b1;
        act_d      = STEP_DOWN;
        rep_run_d  = 1'b0;
        rep_cnt_d  = '0;
      end else if (held_ok) begin
        if (rep_cnt_q == rep_last) begin
          adj_up_d   = (act_q == STEP_UP);
          adj_down_d = (act_q == STEP_DOWN);
          rep_run_d  = 1'b1;
          rep_cnt_d  = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else begin
        act_d     = STEP_NONE;
        rep_run_d = 1'b0;
        rep_cnt_d = '0;
      end
    end

    adj_en_d    = field_onehot(state_d);
    field_sel_d = state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      act_q       <= STEP_NONE;
      rep_run_q   <= 1'b0;
      rep_cnt_q   <= '0;
      idle_q      <= '0;
      blink_q     <= 1'b0;
      adj_up_q    <= 1'b0;
      adj_down_q  <= 1'b0;
      adj_en_q    <= '0;
      field_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      rep_run_q   <= rep_run_d;
      rep_cnt_q   <= rep_cnt_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
      adj_up_q    <= adj_up_d;
      adj_down_q  <= adj_down_d;
      adj_en_q    <= adj_en_d;
      field_sel_q <= field_sel_d;
    end
  end

  assign adj_en    = adj_en_q;
  assign adj_up    = adj_up_q;
  assign adj_down  = adj_down_q;
  assign field_sel = field_sel_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_adjust_ctrl.sv
// Bench for adjust_ctrl: table of mode presses, hand sequences for the timing
// corners, then random buttons/t_1s against a history-based reference model.
module tb_adjust_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;
  localparam int unsigned TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       t_1s = 1'b0;
  logic [6:0] adj_en;
  logic       adj_up;
  logic       adj_down;
  logic [2:0] field_sel;
  logic       blink;

  adjust_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .TIMEOUT_S(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .t_1s(t_1s), .adj_en(adj_en), .adj_up(adj_up),
    .adj_down(adj_down), .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Buttons: index 0 mode, 1 up, 2 down. hist[b][i] = raw sample i edges ago.
  int m_hist[3][16];
  int m_lvl[3];
  int m_rise[3];
  int m_field, m_idle, m_tick, m_held, m_t0, m_cyc;
  int e_up, e_down;

  task automatic m_enter(input int f);
    m_field = f;
    m_idle  = 0;
    m_tick  = 0;
    m_held  = 0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) m_hist[b][i] = 0;
      m_lvl[b]  = 0;
      m_rise[b] = 0;
    end
    m_enter(0);
    m_t0 = 0; m_cyc = 0; e_up = 0; e_down = 0;
  endtask

  task automatic model_step();
    int raw[3];
    int any;
    raw[0] = int'(btn_mode); raw[1] = int'(btn_up); raw[2] = int'(btn_down);
    any = m_rise[0] | m_rise[1] | m_rise[2];
    m_cyc++;
    e_up = 0; e_down = 0;
    if (m_field == 0) begin
      if (m_rise[0] != 0) m_enter(1);
    end else if (m_rise[0] != 0) begin
      m_enter((m_field + 1) % 8);
    end else if (t_1s && any == 0 && m_idle + 1 >= int'(TO)) begin
      m_enter(0);
    end else begin
      if (any != 0) m_idle = 0;
      else if (t_1s) m_idle++;
      if (t_1s) m_tick++;
      if (m_lvl[1] != 0 && m_lvl[2] != 0) m_held = 0;
      else if (m_rise[1] != 0 && m_lvl[2] == 0) begin e_up = 1; m_held = 1; m_t0 = m_cyc; end
      else if (m_rise[2] != 0 && m_lvl[1] == 0) begin e_down = 1; m_held = 2; m_t0 = m_cyc; end
      else if (m_held != 0 && m_lvl[m_held] != 0) begin
        int d;
        d = m_cyc - m_t0;
        if (d == int'(RD) || (d > int'(RD) && (d - int'(RD)) % int'(RR) == 0)) begin
          if (m_held == 1) e_up = 1; else e_down = 1;
        end
      end else m_held = 0;
    end
    // Level flips once the last DB synchronised samples all oppose it.
    for (int b = 0; b < 3; b++) begin
      int flip, old;
      for (int i = 15; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = raw[b];
      flip = 1;
      for (int k = 0; k < int'(DB); k++) if (m_hist[b][2+k] == m_lvl[b]) flip = 0;
      old = m_lvl[b];
      if (flip != 0) m_lvl[b] = 1 - m_lvl[b];
      m_rise[b] = (old == 0 && m_lvl[b] == 1) ? 1 : 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  function automatic int dut_word();
    return int'({adj_en, adj_up, adj_down, field_sel, blink});
  endfunction

  function automatic int model_word();
    int en, bl;
    en = (m_field == 0) ? 0 : (1 << (m_field - 1));
    bl = (m_field != 0) ? (m_tick % 2) : 0;
    return (en << 6) | (e_up << 5) | (e_down << 4) | (m_field << 1) | bl;
  endfunction

  // ---------------- helpers ----------------
  task automatic press_mode();
    btn_mode = 1'b1; tick(DB + 6);
    btn_mode = 1'b0; tick(DB + 6);
  endtask

  task automatic watch(input int n, output int ups, output int downs);
    ups = 0; downs = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      ups += int'(adj_up);
      downs += int'(adj_down);
    end
  endtask

  typedef struct {
    int press;
    int sel;
    int en;
  } vec_t;

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    vec_t tbl[9];
    int   u, d, first, cnt, trans;
    int   offs[16];
    int   exp_off[9];
    int   exp_blink[3];
    int   exp_sel[3];
    int   hold[3];
    int   lvl[3];

    tbl[0] = '{0, 0, 'h00};
    tbl[1] = '{1, 1, 'h01};
    tbl[2] = '{1, 2, 'h02};
    tbl[3] = '{1, 3, 'h04};
    tbl[4] = '{1, 4, 'h08};
    tbl[5] = '{1, 5, 'h10};
    tbl[6] = '{1, 6, 'h20};
    tbl[7] = '{1, 7, 'h40};
    tbl[8] = '{1, 0, 'h00};
    exp_off = '{0, 20, 25, 30, 35, 40, 45, 50, 55};
    exp_blink = '{1, 0, 0};
    exp_sel = '{6, 6, 0};

    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("reset_up", int'(adj_up), 0);
    chk("reset_down", int'(adj_down), 0);
    chk("reset_blink", int'(blink), 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].press != 0) press_mode();
      chk($sformatf("mode_tbl%0d_sel", i), int'(field_sel), tbl[i].sel);
      chk($sformatf("mode_tbl%0d_en", i), int'(adj_en), tbl[i].en);
    end

    // SEC: 3-cycle glitch ignored, clean press pulses 2+DB+1 cycles later
    press_mode();
    chk("sec_sel", int'(field_sel), 1);
    btn_up = 1'b1; tick(3); btn_up = 1'b0;
    watch(15, u, d);
    chk("glitch_pulses", u + d, 0);
    btn_up = 1'b1; first = -1; cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (adj_up) begin cnt++; if (first < 0) first = i; end
    end
    chk("up_latency", first, 7);
    chk("up_single", cnt, 1);
    btn_up = 1'b0; tick(12);

    // MIN: auto-repeat offsets
    press_mode();
    chk("min_en", int'(adj_en), 'h02);
    btn_down = 1'b1; first = -1; cnt = 0;
    for (int i = 1; i <= 66; i++) begin
      tick(1);
      if (adj_down) begin
        if (first < 0) first = i;
        if (cnt < 16) offs[cnt] = i - first;
        cnt++;
      end
    end
    btn_down = 1'b0;
    chk("rep_first_latency", first, 7);
    chk("rep_count", cnt, 9);
    for (int j = 0; j < 9; j++) chk($sformatf("rep_off%0d", j), (j < cnt) ? offs[j] : -1, exp_off[j]);
    tick(15);

    // HOUR: both held, then down released, then up re-pressed
    press_mode();
    chk("hour_sel", int'(field_sel), 3);
    btn_up = 1'b1; btn_down = 1'b1;
    watch(40, u, d);
    chk("both_up", u, 0);
    chk("both_down", d, 0);
    btn_down = 1'b0;
    watch(40, u, d);
    chk("after_rel_up", u, 0);
    chk("after_rel_down", d, 0);
    btn_up = 1'b0; tick(12);
    btn_up = 1'b1; watch(12, u, d);
    chk("repress_up", u, 1);
    btn_up = 1'b0; tick(12);

    // DAY: up held across a mode change
    press_mode();
    chk("day_en", int'(adj_en), 'h08);
    btn_up = 1'b1; watch(10, u, d);
    chk("day_first_up", u, 1);
    btn_mode = 1'b1; u = 0; trans = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      u += int'(adj_up);
      if (adj_en == 7'h10 && trans == 0) trans = 1;
    end
    chk("mode_chg_up", u, 0);
    chk("mode_chg_en", int'(adj_en), 'h10);
    btn_mode = 1'b0;
    watch(12, u, d);
    chk("held_after_chg", u, 0);
    btn_up = 1'b0; tick(12);
    btn_up = 1'b1; watch(12, u, d);
    chk("month_repress", u, 1);
    btn_up = 1'b0; tick(12);

    // YEAR: idle timeout
    press_mode();
    chk("year_sel", int'(field_sel), 6);
    for (int k = 0; k < 3; k++) begin
      t_1s = 1'b1; tick(1); t_1s = 1'b0;
      chk($sformatf("to_blink%0d", k), int'(blink), exp_blink[k]);
      chk($sformatf("to_sel%0d", k), int'(field_sel), exp_sel[k]);
      tick(3);
    end
    chk("to_en", int'(adj_en), 0);

    // reset while auto-repeating
    press_mode();
    btn_up = 1'b1; tick(32);
    chk("pre_reset_up", int'(adj_up), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_word(), 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("post_reset_held", dut_word(), 0);
    btn_up = 1'b0; tick(12);

    // random phase against the reference model
    for (int b = 0; b < 3; b++) begin hold[b] = 0; lvl[b] = 0; end
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl[b] = 1 - lvl[b];
          if (b == 0) hold[b] = lvl[b] ? int'($urandom_range(1, 25)) : int'($urandom_range(30, 200));
          else hold[b] = lvl[b] ? int'($urandom_range(1, 70)) : int'($urandom_range(5, 60));
        end
        hold[b]--;
      end
      btn_mode = lvl[0][0];
      btn_up   = lvl[1][0];
      btn_down = lvl[2][0];
      t_1s = ($urandom_range(0, 29) == 0);
      if (c == 1500 || c == 3000) rst_n = 1'b0;
      if (c == 1502 || c == 3002) rst_n = 1'b1;
      tick(1);
      chk($sformatf("rand_c%0d", c), dut_word(), model_word());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
